// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: decodes the opcode and
// sequences fetch/decode/execute/memory/writeback, tolerating wait-stated memory.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

    state_t r_state;
    logic   w_op_known;

    assign w_op_known = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                        (Op == OP_BEQ)   || (Op == OP_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if ((Op == OP_LW) || (Op == OP_SW)) r_state <= S_MEMADDR;
                    else if (Op == OP_RTYPE)            r_state <= S_EXEC;
                    else if (Op == OP_BEQ)              r_state <= S_BRANCH;
                    else if (Op == OP_J)                r_state <= S_JUMP;
                    else                                r_state <= S_FETCH;
                end
                S_MEMADDR: r_state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   r_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWR:   r_state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:    r_state <= S_RWB;
                S_RWB:     r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                S_JUMP:    r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from state only (plus mem_ready in FETCH and Op in DECODE
    // for the illegal flag) and are forced low while reset is held, without an edge.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        illegal_op  = 1'b0;
        state       = 4'd0;
        if (rst_n) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !w_op_known;
                end
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: illegal_op = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors are
// queued as each step is driven and compared at the following falling edge.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    logic [20:0] exp_q[$];

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Vector layout: state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
    // IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op
    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic pcwc,
                                       input logic iord, input logic mrd, input logic mwr,
                                       input logic m2r, input logic irw, input logic asa,
                                       input logic rw, input logic rd, input logic [1:0] pcs,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic ill);
        return {st, pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop, ill};
    endfunction

    logic [20:0] V_ZERO, V_FETCH_RDY, V_FETCH_WAIT, V_DECODE, V_DECODE_ILL, V_MEMADDR;
    logic [20:0] V_MEMRD, V_MEMWB, V_MEMWR, V_EXEC, V_RWB, V_BRANCH, V_JUMP;

    initial begin
        V_ZERO       = 21'd0;
        V_FETCH_RDY  = mk(4'd0, 1,0,0,1,0,0,1,0,0,0, 2'b00, 2'b01, 2'b00, 0);
        V_FETCH_WAIT = mk(4'd0, 0,0,0,1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0);
        V_DECODE     = mk(4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 0);
        V_DECODE_ILL = mk(4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 1);
        V_MEMADDR    = mk(4'd2, 0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b10, 2'b00, 0);
        V_MEMRD      = mk(4'd3, 0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        V_MEMWB      = mk(4'd4, 0,0,0,0,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 0);
        V_MEMWR      = mk(4'd5, 0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        V_EXEC       = mk(4'd6, 0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b10, 0);
        V_RWB        = mk(4'd7, 0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 0);
        V_BRANCH     = mk(4'd8, 0,1,0,0,0,0,0,1,0,0, 2'b01, 2'b00, 2'b01, 0);
        V_JUMP       = mk(4'd9, 1,0,0,0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 0);
    end

    // scoreboard: pop one expected vector and compare against the live outputs
    task automatic check_out(input string tag);
        logic [20:0] obs;
        logic [20:0] e;
        obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed=%h required=<entry>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
        checks++;
        assert (!(MemRead && MemWrite) && !(RegWrite && MemWrite)) else begin
            errors++;
            $error("FAIL %s_excl: MemRead=%b MemWrite=%b RegWrite=%b required no overlap",
                   tag, MemRead, MemWrite, RegWrite);
        end
    endtask

    // driver: apply inputs for one cycle, queue expectation, check at falling edge
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input logic [20:0] exp);
        Op        = op;
        mem_ready = mr;
        exp_q.push_back(exp);
        @(negedge clk);
        check_out(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    initial begin
        rst_n     = 1'b0;
        Op        = 6'h00;
        mem_ready = 1'b1;
        #3;
        exp_q.push_back(V_ZERO);
        check_out("reset_initial");
        @(posedge clk); @(posedge clk); #1;
        exp_q.push_back(V_ZERO);
        check_out("reset_held");
        rst_n = 1'b1;

        // R-type: 0,1,6,7 then FETCH
        step("rt_fetch",  rnd_op(), 1'b1, V_FETCH_RDY);
        step("rt_decode", 6'h00,    1'b1, V_DECODE);
        step("rt_exec",   rnd_op(), 1'b1, V_EXEC);
        step("rt_rwb",    rnd_op(), 1'b1, V_RWB);

        // LW: 0,1,2,3,4 then FETCH
        step("lw_fetch",   rnd_op(), 1'b1, V_FETCH_RDY);
        step("lw_decode",  6'h23,    1'b1, V_DECODE);
        step("lw_memaddr", 6'h23,    1'b1, V_MEMADDR);
        step("lw_memrd",   rnd_op(), 1'b1, V_MEMRD);
        step("lw_memwb",   rnd_op(), 1'b1, V_MEMWB);

        // SW with FETCH and MEMWR wait states
        step("sw_fetch_w0", rnd_op(), 1'b0, V_FETCH_WAIT);
        step("sw_fetch_w1", rnd_op(), 1'b0, V_FETCH_WAIT);
        step("sw_fetch",    rnd_op(), 1'b1, V_FETCH_RDY);
        step("sw_decode",   6'h2B,    1'b1, V_DECODE);
        step("sw_memaddr",  6'h2B,    1'b1, V_MEMADDR);
        step("sw_memwr_w0", rnd_op(), 1'b0, V_MEMWR);
        step("sw_memwr_w1", rnd_op(), 1'b0, V_MEMWR);
        step("sw_memwr_w2", rnd_op(), 1'b0, V_MEMWR);
        step("sw_memwr",    rnd_op(), 1'b1, V_MEMWR);

        // BEQ then J, 3 cycles each
        step("beq_fetch",  rnd_op(), 1'b1, V_FETCH_RDY);
        step("beq_decode", 6'h04,    1'b1, V_DECODE);
        step("beq_branch", rnd_op(), 1'b1, V_BRANCH);
        step("j_fetch",    rnd_op(), 1'b1, V_FETCH_RDY);
        step("j_decode",   6'h02,    1'b1, V_DECODE);
        step("j_jump",     rnd_op(), 1'b1, V_JUMP);

        // unsupported opcode: one-cycle illegal_op then straight back to FETCH
        step("ill_fetch",  rnd_op(), 1'b1, V_FETCH_RDY);
        step("ill_decode", 6'h3F,    1'b1, V_DECODE_ILL);
        step("ill_after",  6'h3F,    1'b1, V_FETCH_RDY);

        // LW with MEMRD wait states
        step("lww_decode",  6'h23,    1'b1, V_DECODE);
        step("lww_memaddr", 6'h23,    1'b1, V_MEMADDR);
        step("lww_memrd_w0", rnd_op(), 1'b0, V_MEMRD);
        step("lww_memrd_w1", rnd_op(), 1'b0, V_MEMRD);
        step("lww_memrd",   rnd_op(), 1'b1, V_MEMRD);
        step("lww_memwb",   rnd_op(), 1'b1, V_MEMWB);

        // asynchronous reset while stalled in MEMWR
        step("rst_fetch0",   rnd_op(), 1'b1, V_FETCH_RDY);
        step("rst_decode",   6'h2B,    1'b1, V_DECODE);
        step("rst_memaddr",  6'h2B,    1'b1, V_MEMADDR);
        step("rst_memwr_w0", rnd_op(), 1'b0, V_MEMWR);
        Op        = rnd_op();
        mem_ready = 1'b0;
        #2;
        exp_q.push_back(V_MEMWR);
        check_out("rst_pre");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(V_ZERO);
        check_out("rst_async");
        @(posedge clk); #1;
        exp_q.push_back(V_ZERO);
        check_out("rst_held_edge");
        #2;
        rst_n = 1'b1;
        #1;
        step("rst_resume_fetch", rnd_op(), 1'b1, V_FETCH_RDY);
        step("rst_resume_decode", 6'h00,   1'b1, V_DECODE);
        step("rst_resume_exec",  rnd_op(), 1'b1, V_EXEC);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d entries left expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
